master_bus_arbiter: RTL and testbench
=====================================

Name: master_bus_arbiter

Overview:
- Parametrised successor to the two-master bus mux: arbitrates NUM_MASTERS memory-bus masters (CPU data port, debug probe, future DMA) onto one slave-side bus feeding the slave address decoder.
- Round-robin fair, multi-cycle slave transactions via a ready handshake, per-master registered acknowledge, read-data and error return.
- Replaces the fixed useA select.

Parameters:
- NUM_MASTERS, 2, number of master ports (≥2).
- ADDR_W, 30, word address width.
- DATA_W, 32, data width.
- MASK_W, DATA_W/8, byte-mask width.
- TIMEOUT_CYCLES, 16, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- m_address  in  NUM_MASTERS*ADDR_W  per-master word address; slice i belongs to master i.
- m_mem_read  in  NUM_MASTERS  per-master read request.
- m_mem_write  in  NUM_MASTERS  per-master write request.
- m_mask_byte  in  NUM_MASTERS*MASK_W  per-master byte enables.
- m_write_data  in  NUM_MASTERS*DATA_W  per-master write data.
- m_read_data  out  NUM_MASTERS*DATA_W  per-master captured read data.
- m_ack  out  NUM_MASTERS  one-cycle completion pulse.
- m_error  out  NUM_MASTERS  one-cycle error pulse, coincident with m_ack.
- s_address  out  ADDR_W  slave-side address.
- s_mem_read  out  1  slave-side read strobe.
- s_mem_write  out  1  slave-side write strobe.
- s_mask_byte  out  MASK_W  slave-side byte enables.
- s_write_data  out  DATA_W  slave-side write data.
- s_read_data  in  DATA_W  slave read data, valid when s_ready.
- s_ready  in  1  slave completes the current access.
- s_error  in  1  slave/decoder error (invalid address), sampled with s_ready.
- grant  out  NUM_MASTERS  one-hot owner of the slave bus (0 when idle).

Behaviour:
- Interface: single clock clk; rst is synchronous, active-high.
- Reset state: state=IDLE, rr_ptr=NUM_MASTERS-1 so master 0 wins first, grant=0, m_ack=0, m_error=0, all m_read_data=0, s_mem_read=s_mem_write=0, s_address/s_mask_byte/s_write_data=0.
- A master requests when m_mem_read[i] | m_mem_write[i]. Both set is forwarded unchanged; the slave decides.
- FSM states and transitions:
  - IDLE: if any request is present, pick the first requester searching rr_ptr+1, rr_ptr+2, … with modulo-NUM_MASTERS wrap. At the clock edge: latch that master's full command into the slave-side registers, set grant one-hot, set rr_ptr to the winner, go to ACCESS. With no requests, stay in IDLE with all strobes 0.
  - ACCESS: s_* outputs are driven from the latched command, so master changes are ignored. If s_ready: capture s_read_data into m_read_data[g] (0 if s_error or for writes), go to RESP. Otherwise hold.
  - RESP: m_ack[g]=1 and m_error[g]=s_error as registered. s_mem_read=s_mem_write=0. grant stays set. Next state is IDLE.
- Latency:
  - Request seen in IDLE at cycle 0; slave strobes in cycle 1.
  - If s_ready in cycle 1, m_ack in cycle 2; IDLE in cycle 3.
  - Minimum 3 cycles per access; back-to-back grants every 3 cycles.
- Master protocol: hold the command until m_ack. In the cycle after m_ack, either drop the request or present the next command; the IDLE sample in that cycle treats it as new.
- m_read_data[i] holds its value until master i's next completed access.
- Fairness: a continuously requesting master cannot win twice while another master is requesting.
- A master that drops its request mid-transaction still gets its ack.
- rst during ACCESS or RESP: abort immediately to the reset state. No ack is issued; the slave strobe drops the next cycle.
- NUM_MASTERS need not be a power of two; the wrap is explicit modulo.

Optional Feature:
- Macro: MASTER_BUS_ARB_TIMEOUT_EN.
- With the macro: an ACCESS cycle counter (cleared on entry) forces RESP after TIMEOUT_CYCLES cycles without s_ready. That completion gives m_error=1, m_read_data[g]=0, and s_* strobes deasserted.
- Without the macro: ACCESS waits indefinitely, no counter is synthesised, and TIMEOUT_CYCLES is unused.

Decomposition:
- Add to the MemoryBus package: an ArbState enum (IDLE, ACCESS, RESP) and a packed ArbCmd struct (address, mem_read, mem_write, mask_byte, write_data) used for the latched command.
- Sub-module rr_picker, combinational: request vector + rr_ptr → one-hot winner and index. Reusable by future arbiters.

Test Plan:
- Single master 0 reads address 0x10, slave s_ready=1 in first ACCESS cycle with data 0xDEADBEEF → s_mem_read cycle 1, m_ack[0] cycle 2, m_read_data[0]=0xDEADBEEF.
- Masters 0 and 1 request continuously → grants alternate 0,1,0,1; no master gets two grants in a row.
- Slave holds s_ready=0 for 5 cycles → s_* stable all 5 cycles; ack on the 7th cycle after the request.
- Write mask 4'b0011 data 0x12345678, s_error=1 with s_ready → m_ack and m_error pulse together; m_read_data=0.
- rst asserted mid-ACCESS → next cycle grant=0, strobes 0, no m_ack; master 0 wins first after reset.
- With MASTER_BUS_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, s_ready never set → m_ack and m_error exactly at timeout, then IDLE.

Source files
------------

// File: rtl/master_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : master_bus_arbiter_pkg
// Purpose : Shared arbiter state encoding and index helpers for the memory bus.
// Revision: 1.0
// ============================================================================
package master_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    // Index width that stays legal for a single-entry vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Explicit modulo wrap; base < n and step <= n keep the sum below 2n.
    function automatic int wrap_idx(input int base, input int step, input int n);
        int s;
        s = base + step;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/master_bus_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module  : rr_picker
// Purpose : Combinational round-robin pick: first requester after i_ptr.
// Revision: 1.0
// ============================================================================
module rr_picker
    import master_bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = idx_width(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [IDX_W-1:0]       i_ptr,
    output logic [NUM_MASTERS-1:0] o_winner,
    output logic [IDX_W-1:0]       o_winner_idx,
    output logic                   o_any
);

    always_comb begin
        int   w_cand;
        logic w_found;
        o_winner     = '0;
        o_winner_idx = '0;
        o_any        = |i_req;
        w_found      = 1'b0;
        w_cand       = 0;
        // Search ptr+1 .. ptr+N so the previous owner is considered last.
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            w_cand = wrap_idx(int'(i_ptr), k, NUM_MASTERS);
            if (!w_found && i_req[w_cand]) begin
                w_found           = 1'b1;
                o_winner[w_cand]  = 1'b1;
                o_winner_idx      = IDX_W'(w_cand);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/master_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : master_bus_arbiter
// Purpose : Round-robin arbiter of NUM_MASTERS masters onto one slave bus.
//           Optional access watchdog: MASTER_BUS_ARB_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
module master_bus_arbiter
    import master_bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_W         = 30,
    parameter int DATA_W         = 32,
    parameter int MASK_W         = DATA_W / 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_address,
    input  logic [NUM_MASTERS-1:0]        m_mem_read,
    input  logic [NUM_MASTERS-1:0]        m_mem_write,
    input  logic [NUM_MASTERS*MASK_W-1:0] m_mask_byte,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_write_data,
    output logic [NUM_MASTERS*DATA_W-1:0] m_read_data,
    output logic [NUM_MASTERS-1:0]        m_ack,
    output logic [NUM_MASTERS-1:0]        m_error,
    output logic [ADDR_W-1:0]             s_address,
    output logic                          s_mem_read,
    output logic                          s_mem_write,
    output logic [MASK_W-1:0]             s_mask_byte,
    output logic [DATA_W-1:0]             s_write_data,
    input  logic [DATA_W-1:0]             s_read_data,
    input  logic                          s_ready,
    input  logic                          s_error,
    output logic [NUM_MASTERS-1:0]        grant
);

    localparam int c_IDX_W = idx_width(NUM_MASTERS);

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic              mem_read;
        logic              mem_write;
        logic [MASK_W-1:0] mask_byte;
        logic [DATA_W-1:0] write_data;
    } arb_cmd_t;

    if (NUM_MASTERS < 2) begin : g_bad_num_masters
        $error("master_bus_arbiter: NUM_MASTERS must be at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("master_bus_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    arb_state_t                r_state;
    arb_state_t                w_state_nxt;
    logic [c_IDX_W-1:0]        r_rr_ptr;
    logic [c_IDX_W-1:0]        r_gidx;
    logic [NUM_MASTERS-1:0]    r_grant;
    logic [NUM_MASTERS-1:0]    r_ack;
    logic [NUM_MASTERS-1:0]    r_err;
    logic [NUM_MASTERS*DATA_W-1:0] r_rdata;
    arb_cmd_t                  r_cmd;
    arb_cmd_t                  w_sel_cmd;
    logic [NUM_MASTERS-1:0]    w_req;
    logic [NUM_MASTERS-1:0]    w_winner;
    logic [c_IDX_W-1:0]        w_widx;
    logic                      w_any;
    logic                      w_timeout;
    logic                      w_done;
    logic                      w_done_err;
    logic [DATA_W-1:0]         w_cap_data;

    assign w_req = m_mem_read | m_mem_write;

    rr_picker #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (c_IDX_W)
    ) u_rr_picker (
        .i_req        (w_req),
        .i_ptr        (r_rr_ptr),
        .o_winner     (w_winner),
        .o_winner_idx (w_widx),
        .o_any        (w_any)
    );

    always_comb begin
        w_sel_cmd            = '0;
        w_sel_cmd.address    = m_address[int'(w_widx)*ADDR_W +: ADDR_W];
        w_sel_cmd.mem_read   = m_mem_read[w_widx];
        w_sel_cmd.mem_write  = m_mem_write[w_widx];
        w_sel_cmd.mask_byte  = m_mask_byte[int'(w_widx)*MASK_W +: MASK_W];
        w_sel_cmd.write_data = m_write_data[int'(w_widx)*DATA_W +: DATA_W];
    end

`ifdef MASTER_BUS_ARB_TIMEOUT_EN
    localparam int c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [c_CNT_W-1:0] r_tcnt;

    // Fires on the last permitted ACCESS cycle that still lacks s_ready.
    assign w_timeout = (r_state == ACCESS) && !s_ready &&
                       (r_tcnt == c_CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || (r_state != ACCESS)) begin
            r_tcnt <= '0;
        end else if (!w_timeout) begin
            r_tcnt <= r_tcnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    assign w_done     = (r_state == ACCESS) && (s_ready || w_timeout);
    assign w_done_err = s_ready ? s_error : 1'b1;
    // Only a clean read returns data; writes, errors and timeouts return zero.
    assign w_cap_data = (s_ready && !s_error && r_cmd.mem_read) ? s_read_data : '0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any)  w_state_nxt = ACCESS;
            ACCESS:  if (w_done) w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_rr_ptr <= c_IDX_W'(NUM_MASTERS - 1);
            r_gidx   <= '0;
            r_grant  <= '0;
            r_ack    <= '0;
            r_err    <= '0;
            r_rdata  <= '0;
            r_cmd    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ack   <= '0;
            r_err   <= '0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_cmd    <= w_sel_cmd;
                        r_grant  <= w_winner;
                        r_gidx   <= w_widx;
                        r_rr_ptr <= w_widx;
                    end
                end
                ACCESS: begin
                    if (w_done) begin
                        r_ack[r_gidx] <= 1'b1;
                        r_err[r_gidx] <= w_done_err;
                        r_rdata[int'(r_gidx)*DATA_W +: DATA_W] <= w_cap_data;
                    end
                end
                RESP:    r_grant <= '0;
                default: r_grant <= '0;
            endcase
        end
    end

    assign s_address    = r_cmd.address;
    assign s_mask_byte  = r_cmd.mask_byte;
    assign s_write_data = r_cmd.write_data;
    assign s_mem_read   = (r_state == ACCESS) && r_cmd.mem_read;
    assign s_mem_write  = (r_state == ACCESS) && r_cmd.mem_write;
    assign grant        = r_grant;
    assign m_ack        = r_ack;
    assign m_error      = r_err;
    assign m_read_data  = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_master_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_master_bus_arbiter
// Purpose : Directed plus randomized transaction bench for master_bus_arbiter.
// Revision: 1.0
// ============================================================================
module tb_master_bus_arbiter;

    localparam int N  = 3;
    localparam int AW = 30;
    localparam int DW = 32;
    localparam int MW = 4;
    localparam int TO = 4;
`ifdef MASTER_BUS_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N*AW-1:0] m_address = '0;
    logic [N-1:0]    m_mem_read = '0;
    logic [N-1:0]    m_mem_write = '0;
    logic [N*MW-1:0] m_mask_byte = '0;
    logic [N*DW-1:0] m_write_data = '0;
    logic [N*DW-1:0] m_read_data;
    logic [N-1:0]    m_ack;
    logic [N-1:0]    m_error;
    logic [AW-1:0]   s_address;
    logic            s_mem_read;
    logic            s_mem_write;
    logic [MW-1:0]   s_mask_byte;
    logic [DW-1:0]   s_write_data;
    logic [DW-1:0]   s_read_data = '0;
    logic            s_ready = 1'b0;
    logic            s_error = 1'b0;
    logic [N-1:0]    grant;

    master_bus_arbiter #(
        .NUM_MASTERS    (N),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .MASK_W         (MW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .m_address    (m_address),
        .m_mem_read   (m_mem_read),
        .m_mem_write  (m_mem_write),
        .m_mask_byte  (m_mask_byte),
        .m_write_data (m_write_data),
        .m_read_data  (m_read_data),
        .m_ack        (m_ack),
        .m_error      (m_error),
        .s_address    (s_address),
        .s_mem_read   (s_mem_read),
        .s_mem_write  (s_mem_write),
        .s_mask_byte  (s_mask_byte),
        .s_write_data (s_write_data),
        .s_read_data  (s_read_data),
        .s_ready      (s_ready),
        .s_error      (s_error),
        .grant        (grant)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: who owned the bus last, each master's last result,
    // and each master's currently presented command.
    int            last_win = N - 1;
    logic [DW-1:0] exp_rd [N];
    logic [N-1:0]  pend = '0;
    logic [AW-1:0] c_addr [N];
    logic          c_rd   [N];
    logic          c_wr   [N];
    logic [MW-1:0] c_mask [N];
    logic [DW-1:0] c_wd   [N];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int i, input logic [AW-1:0] a, input logic rd, input logic wr,
                           input logic [MW-1:0] mk, input logic [DW-1:0] wd);
        c_addr[i] = a; c_rd[i] = rd; c_wr[i] = wr; c_mask[i] = mk; c_wd[i] = wd;
        m_address[i*AW +: AW]    = a;
        m_mem_read[i]            = rd;
        m_mem_write[i]           = wr;
        m_mask_byte[i*MW +: MW]  = mk;
        m_write_data[i*DW +: DW] = wd;
        pend[i]                  = 1'b1;
    endtask

    task automatic rand_cmd(input int i);
        int kind;
        kind = $urandom_range(0, 2);
        set_cmd(i, AW'($urandom), kind != 1, kind != 0, MW'($urandom), $urandom);
    endtask

    task automatic drop(input int i);
        m_mem_read[i]  = 1'b0;
        m_mem_write[i] = 1'b0;
        pend[i]        = 1'b0;
    endtask

    function automatic int pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic check_rdata(input string tag);
        for (int i = 0; i < N; i++) check(tag, 64'(m_read_data[i*DW +: DW]), 64'(exp_rd[i]));
    endtask

    // Called in an IDLE cycle; runs one whole access and returns in the
    // following IDLE cycle after the winner drops or re-arms its request.
    task automatic txn(input int delay, input logic err, input logic [DW-1:0] data,
                       input bit drop_mid, input bit rearm);
        int            w;
        bit            tout;
        int            n_stable;
        logic [AW-1:0] a;
        logic          rd, wr;
        logic [MW-1:0] mk;
        logic [DW-1:0] wd;
        logic [DW-1:0] exp_data;
        logic          exp_err;
        w = pick(pend, last_win);
        if (w < 0) begin
            step();
            check("idle_grant", 64'(grant), 64'(0));
            check("idle_strobe", 64'({s_mem_read, s_mem_write}), 64'(0));
            return;
        end
        a = c_addr[w]; rd = c_rd[w]; wr = c_wr[w]; mk = c_mask[w]; wd = c_wd[w];
        tout     = TO_EN && (delay >= TO);
        n_stable = tout ? (TO - 1) : delay;
        step();
        if (drop_mid) begin
            drop(w);
            m_address[w*AW +: AW] = ~a;
        end
        check("acc_grant", 64'(grant), 64'(1) << w);
        check("acc_rd", 64'(s_mem_read), 64'(rd));
        check("acc_wr", 64'(s_mem_write), 64'(wr));
        check("acc_addr", 64'(s_address), 64'(a));
        check("acc_mask", 64'(s_mask_byte), 64'(mk));
        check("acc_wdata", 64'(s_write_data), 64'(wd));
        check("acc_noack", 64'(m_ack), 64'(0));
        for (int d = 0; d < n_stable; d++) begin
            s_read_data = $urandom;
            step();
            check("hold_addr", 64'(s_address), 64'(a));
            check("hold_strobe", 64'({s_mem_read, s_mem_write}), 64'({rd, wr}));
            check("hold_noack", 64'(m_ack), 64'(0));
        end
        s_ready     = !tout;
        s_read_data = data;
        s_error     = err;
        step();
        s_ready = 1'b0;
        s_error = 1'b0;
        exp_err  = tout ? 1'b1 : err;
        exp_data = (tout || err || !rd) ? '0 : data;
        exp_rd[w] = exp_data;
        last_win  = w;
        check("resp_ack", 64'(m_ack), 64'(1) << w);
        check("resp_err", 64'(m_error), exp_err ? (64'(1) << w) : 64'(0));
        check("resp_strobe", 64'({s_mem_read, s_mem_write}), 64'(0));
        check("resp_grant", 64'(grant), 64'(1) << w);
        check_rdata("resp_rdata");
        step();
        check("post_grant", 64'(grant), 64'(0));
        check("post_ack", 64'(m_ack), 64'(0));
        if (rearm) rand_cmd(w);
        else drop(w);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < N; i++) exp_rd[i] = '0;
        rst = 1'b1;
        step();
        step();
        check("rst_grant", 64'(grant), 64'(0));
        check("rst_ack", 64'({m_ack, m_error}), 64'(0));
        check("rst_strobe", 64'({s_mem_read, s_mem_write}), 64'(0));
        check("rst_saddr", 64'(s_address), 64'(0));
        check("rst_smask_wd", 64'({s_mask_byte, s_write_data}), 64'(0));
        check_rdata("rst_rdata");
        rst = 1'b0;
        step();

        // Single read from master 0 completing in the first ACCESS cycle.
        set_cmd(0, AW'('h10), 1'b1, 1'b0, 4'hF, '0);
        txn(0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);

        // Two continuous requesters must alternate.
        rand_cmd(0);
        rand_cmd(1);
        for (int t = 0; t < 4; t++) txn(0, 1'b0, $urandom, 1'b0, 1'b1);
        txn(0, 1'b0, $urandom, 1'b0, 1'b0);
        drop(0);
        drop(1);

        // Slave stalls for five cycles.
        set_cmd(2, AW'('h2AB), 1'b1, 1'b0, 4'hF, '0);
        txn(5, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0);

        // Write with a decoder error.
        set_cmd(1, AW'('h3FFF_0000), 1'b0, 1'b1, 4'b0011, 32'h12345678);
        txn(0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);

        // Requester withdraws mid-access and still receives its ack.
        set_cmd(0, AW'('h55), 1'b1, 1'b0, 4'hC, '0);
        txn(2, 1'b0, 32'hA5A5_5A5A, 1'b1, 1'b0);

        // Reset in the middle of an access.
        rand_cmd(2);
        step();
        check("rst_mid_active", 64'(grant), 64'(1) << 2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_grant", 64'(grant), 64'(0));
        check("rst_mid_strobe", 64'({s_mem_read, s_mem_write}), 64'(0));
        check("rst_mid_ack", 64'(m_ack), 64'(0));
        last_win = N - 1;
        for (int i = 0; i < N; i++) exp_rd[i] = '0;
        check_rdata("rst_mid_rdata");
        rand_cmd(0);
        txn(1, 1'b0, $urandom, 1'b0, 1'b0);
        txn(0, 1'b0, $urandom, 1'b0, 1'b0);

`ifdef MASTER_BUS_ARB_TIMEOUT_EN
        // Slave never answers: watchdog completes with an error.
        set_cmd(1, AW'('h77), 1'b1, 1'b0, 4'hF, '0);
        txn(TO + 3, 1'b0, 32'h1111_2222, 1'b0, 1'b0);
`endif

        // Randomized traffic against the reference model.
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1)) rand_cmd(i);
            end
            txn($urandom_range(0, 3), $urandom_range(0, 3) == 0, $urandom,
                $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
